// File: rtl/riscv_if.sv
// Instruction fetch stage: issues word-aligned fetches, queues in-order responses
// as {pc, inst} pairs for decode, and flushes/discards stale work on redirect.
module riscv_if #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [31:0]   pc_mem_q   [FIFO_DEPTH];
    logic [31:0]   inst_mem_q [FIFO_DEPTH];
    logic [CW:0]   credit_sum;
    logic          issue, push, pop;

    // Stale in-flight requests still hold a slot, so the queue can never overflow.
    assign credit_sum   = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_o   = !rst && !redirect_i
                          && (inflight_q < CW'(MAX_OUTSTANDING))
                          && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o  = fpc_q;
    assign inst_valid_o = !rst && (count_q != '0);
    assign pc_o         = inst_valid_o ? pc_mem_q[rptr_q]   : 32'h0;
    assign inst_o       = inst_valid_o ? inst_mem_q[rptr_q] : NOP;

    assign issue = imem_req_o && imem_gnt_i;
    assign push  = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign pop   = inst_valid_o && inst_ready_i && !redirect_i;

    always_comb begin
        fpc_d      = fpc_q;
        rpc_d      = rpc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        if (redirect_i) begin
            fpc_d      = {redirect_pc_i[31:2], 2'b00};
            rpc_d      = {redirect_pc_i[31:2], 2'b00};
            inflight_d = inflight_q - CW'(imem_rvalid_i);
            discard_d  = inflight_q - CW'(imem_rvalid_i);
            count_d    = '0;
            rptr_d     = '0;
            wptr_d     = '0;
        end else begin
            if (issue) fpc_d = fpc_q + 32'd4;
            inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid_i);
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
            if (push) begin
                rpc_d  = rpc_q + 32'd4;
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q      <= RESET_PC;
            rpc_q      <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]   <= rpc_q;
            inst_mem_q[wptr_q] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_riscv_if.sv
// Directed bench for riscv_if: in-order memory model returning address as data,
// pop monitor checking the {pc, inst} stream against an expected PC sequence.
module tb_riscv_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    riscv_if #(.RESET_PC(32'h100), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .pc_o(pc_o), .inst_o(inst_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       memq[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, lat = 1, npops = 0, base;
    logic        nx_rst = 1'b1, nx_redir = 1'b0, nx_ready = 1'b1, nx_gnt = 1'b1;
    logic [31:0] nx_rpc = 32'h0, exp_pc = 32'h100, last_iss = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs and memory response at negedge, sample 1ns later.
    task automatic tick();
        @(negedge clk);
        cyc++;
        rst           = nx_rst;
        redirect_i    = nx_redir;
        redirect_pc_i = nx_rpc;
        inst_ready_i  = nx_ready;
        imem_gnt_i    = nx_gnt;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memq[0].addr;
            void'(memq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        #1;
        if (imem_req_o && imem_gnt_i) begin
            memq.push_back('{due: cyc + lat, addr: imem_addr_o});
            last_iss = imem_addr_o;
        end
        if (inst_valid_o && inst_ready_i && !redirect_i) begin
            check("pop_pc", pc_o, exp_pc);
            check("pop_inst", inst_o, exp_pc);
            exp_pc = exp_pc + 32'd4;
            npops++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready_i = 1'b1;
        #1;
        check("rst_req", {31'h0, imem_req_o}, 32'h0);
        check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h13);
        run(2);

        // Release reset: issue on 1st cycle, head visible on 3rd.
        nx_rst = 1'b0;
        tick();
        check("first_req", {31'h0, imem_req_o}, 32'h1);
        check("first_addr", imem_addr_o, 32'h100);
        tick();
        check("lat_valid_c2", {31'h0, inst_valid_o}, 32'h0);
        tick();
        check("lat_valid_c3", {31'h0, inst_valid_o}, 32'h1);
        base = npops;
        run(10);
        check("stream_rate", npops - base, 10);

        // Backpressure: queue fills, requests stop.
        nx_ready = 1'b0;
        run(5);
        check("bp_req_off", {31'h0, imem_req_o}, 32'h0);
        check("bp_valid", {31'h0, inst_valid_o}, 32'h1);
        nx_ready = 1'b1;
        base = npops;
        run(10);
        check("bp_resume_rate", npops - base, 10);

        // Grant stall: address held, then resumes in order.
        nx_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req", {31'h0, imem_req_o}, 32'h1);
            check("stall_addr", imem_addr_o, last_iss + 32'd4);
        end
        nx_gnt = 1'b1;
        run(8);

        // Redirect coincident with rvalid and a pop.
        exp_pc = 32'h3000; nx_redir = 1'b1; nx_rpc = 32'h3000;
        tick();
        check("coinc_valid", {31'h0, inst_valid_o}, 32'h1);
        check("coinc_req", {31'h0, imem_req_o}, 32'h0);
        nx_redir = 1'b0;
        base = npops;
        tick();
        check("coinc_addr", imem_addr_o, 32'h3000);
        run(8);
        check("coinc_resume", {31'h0, npops > base}, 32'h1);

        // 3-cycle memory, redirect with requests in flight.
        lat = 3;
        run(8);
        exp_pc = 32'h2000; nx_redir = 1'b1; nx_rpc = 32'h2002;
        tick();
        check("redir_req", {31'h0, imem_req_o}, 32'h0);
        nx_redir = 1'b0;
        base = npops;
        tick();
        check("redir_addr", imem_addr_o, 32'h2000);
        run(12);
        check("redir_resume", {31'h0, npops > base}, 32'h1);

        // Back-to-back redirects: last one wins.
        nx_redir = 1'b1; nx_rpc = 32'h4000;
        tick();
        exp_pc = 32'h5004; nx_rpc = 32'h5004;
        tick();
        nx_redir = 1'b0;
        base = npops;
        run(12);
        check("b2b_resume", {31'h0, npops > base}, 32'h1);

        // Async reset between clock edges.
        lat = 1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", {31'h0, imem_req_o}, 32'h0);
        check("arst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("arst_pc", pc_o, 32'h0);
        check("arst_inst", inst_o, 32'h13);
        memq.delete();
        nx_rst = 1'b1;
        tick();
        memq.delete();
        exp_pc = 32'h100; nx_rst = 1'b0;
        tick();
        check("arst_addr", imem_addr_o, 32'h100);
        base = npops;
        run(10);
        check("arst_resume", {31'h0, npops > base}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
